// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer and its alu.
// Also holds the funct3 signedness helpers.
package muldiv_sequencer_pkg;

    localparam int unsigned MULDIV_LATENCY = 36;

    localparam logic [3:0] ALU_OPCODE_ADD      = 4'd0;
    localparam logic [3:0] ALU_OPCODE_SUBTRACT = 4'd1;
    localparam logic [3:0] ALU_OPCODE_AND      = 4'd2;
    localparam logic [3:0] ALU_OPCODE_OR       = 4'd3;
    localparam logic [3:0] ALU_OPCODE_XOR      = 4'd4;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    function automatic logic op1_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) || (f == FUNCT3_DIV) ||
               (f == FUNCT3_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_DIV) || (f == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the muldiv sequencer.
interface muldiv_sequencer_if;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, kill, funct3, operand1, operand2,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, funct3, operand1, operand2,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_sequencer_alu.sv
// Purely combinational 32-bit alu shared with the execute stage.
module muldiv_sequencer_alu
    import muldiv_sequencer_pkg::*;
(
    input  logic [3:0]  operation_i,
    input  logic [31:0] operand1_i,
    input  logic [31:0] operand2_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = '0;
        case (operation_i)
            ALU_OPCODE_ADD:      result_o = operand1_i + operand2_i;
            ALU_OPCODE_SUBTRACT: result_o = operand1_i - operand2_i;
            ALU_OPCODE_AND:      result_o = operand1_i & operand2_i;
            ALU_OPCODE_OR:       result_o = operand1_i | operand2_i;
            ALU_OPCODE_XOR:      result_o = operand1_i ^ operand2_i;
            default:             result_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Fixed-latency RV32M multiply/divide sequencer: shift-add multiply and restoring
// divide on magnitudes, with sign fixup, all arithmetic through one shared alu.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input logic               clock,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned ITERS = 32;

    typedef enum logic [2:0] {
        StIdle, StPrep1, StPrep2, StIter, StFixLo, StFixHi, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      x_q, x_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      result_q, result_d;
    logic [ITERS-1:0] iter_q, iter_d;
    logic             neg1_q, neg1_d, neg2_q, neg2_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [31:0] rem_shift, y_mag;
    logic        is_div, neg_prod, accept, carry, sel_hi;

    muldiv_sequencer_alu u_alu (
        .operation_i (alu_op),
        .operand1_i  (alu_a),
        .operand2_i  (alu_b),
        .result_o    (alu_y)
    );

    // Multiply: x=multiplicand, {hi,lo}=accumulator. Divide: y=divisor, hi=r, lo=q.
    assign is_div    = funct3_q[2];
    assign neg_prod  = neg1_q ^ neg2_q;
    assign rem_shift = {hi_q[30:0], lo_q[31]};
    assign accept    = hi_q[31] | (rem_shift >= y_q);
    assign carry     = alu_y < x_q;
    assign sel_hi    = is_div ? funct3_q[1] : (funct3_q[1:0] != 2'b00);

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        x_d      = x_q;
        y_d      = y_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        iter_d   = iter_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        done_d   = 1'b0;
        alu_op   = ALU_OPCODE_ADD;
        alu_a    = '0;
        alu_b    = '0;
        y_mag    = y_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.kill) begin
                    funct3_d = bus.funct3;
                    x_d      = bus.operand1;
                    y_d      = bus.operand2;
                    state_d  = StPrep1;
                end
            end
            StPrep1: begin
                alu_op = ALU_OPCODE_SUBTRACT;
                alu_b  = x_q;
                neg1_d = op1_signed(funct3_q) & x_q[31];
                if (neg1_d) x_d = alu_y;
                state_d = StPrep2;
            end
            StPrep2: begin
                alu_op = ALU_OPCODE_SUBTRACT;
                alu_b  = y_q;
                neg2_d = op2_signed(funct3_q) & y_q[31];
                if (neg2_d) y_mag = alu_y;
                y_d     = y_mag;
                hi_d    = '0;
                lo_d    = is_div ? x_q : y_mag;
                iter_d  = {{(ITERS-1){1'b0}}, 1'b1};
                state_d = StIter;
            end
            StIter: begin
                if (is_div) begin
                    alu_op = ALU_OPCODE_SUBTRACT;
                    alu_a  = rem_shift;
                    alu_b  = y_q;
                    hi_d   = accept ? alu_y : rem_shift;
                    lo_d   = {lo_q[30:0], accept};
                end else begin
                    alu_a = hi_q;
                    alu_b = x_q;
                    if (lo_q[0]) begin
                        hi_d = {carry, alu_y[31:1]};
                        lo_d = {alu_y[0], lo_q[31:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[31:1]};
                        lo_d = {hi_q[0], lo_q[31:1]};
                    end
                end
                iter_d = iter_q << 1;
                if (iter_q[ITERS-1]) state_d = StFixLo;
            end
            StFixLo: begin
                // Divide by zero keeps the all-ones quotient unsigned.
                alu_op = ALU_OPCODE_SUBTRACT;
                alu_b  = lo_q;
                if (neg_prod && !(is_div && (y_q == '0))) lo_d = alu_y;
                state_d = StFixHi;
            end
            StFixHi: begin
                // Re-negating the remainder magnitude restores operand1 on divide by zero.
                if (is_div) begin
                    alu_op = ALU_OPCODE_SUBTRACT;
                    alu_b  = hi_q;
                    if (neg1_q) hi_d = alu_y;
                end else begin
                    alu_a = ~hi_q;
                    alu_b = {31'b0, lo_q == '0};
                    if (neg_prod) hi_d = alu_y;
                end
                done_d   = 1'b1;
                result_d = sel_hi ? hi_d : lo_d;
                state_d  = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (bus.kill && (state_q != StIdle)) begin
            state_d  = StIdle;
            done_d   = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            funct3_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            iter_q   <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            iter_q   <= iter_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, handshake, kill and reset.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        int unsigned acc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pops one expectation and checks value and latency.
    always @(posedge clock) begin
        #1;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, bus.result, e.res);
                check({e.name, "_latency"}, cyc - e.acc, MULDIV_LATENCY);
            end
        end
    end

    // Called just after a negedge with the DUT idle; returns just after the next negedge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit track, input logic [31:0] exp, input string name);
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.operand1 = a;
        bus.operand2 = b;
        if (track) begin
            exp_t e;
            e.res  = exp;
            e.acc  = cyc + 1;
            e.name = name;
            sb.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
        bus.start    = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.operand1 = $urandom;
        bus.operand2 = $urandom;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: got busy=1 after 100 cycles expected busy=0", name);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        issue(f, a, b, 1'b1, exp, name);
        wait_idle(name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.kill     = 1'b0;
        bus.funct3   = '0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);

        run_op(FUNCT3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        run_op(FUNCT3_MULH,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, "mulh");
        run_op(FUNCT3_MULHU,  32'd7,        32'hFFFF_FFFD, 32'h0000_0006, "mulhu");
        run_op(FUNCT3_MULHSU, 32'd7,        32'hFFFF_FFFD, 32'h0000_0006, "mulhsu");
        run_op(FUNCT3_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div");
        run_op(FUNCT3_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "rem");
        run_op(FUNCT3_DIVU,   32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, "divu");
        run_op(FUNCT3_REMU,   32'hFFFF_FFF9, 32'd2,        32'h0000_0001, "remu");
        run_op(FUNCT3_DIV,    32'd5,        32'd0,         32'hFFFF_FFFF, "div_by_zero");
        run_op(FUNCT3_REM,    32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, "rem_by_zero");
        run_op(FUNCT3_DIVU,   32'd9,        32'd0,         32'hFFFF_FFFF, "divu_by_zero");
        run_op(FUNCT3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
        run_op(FUNCT3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow");
        run_op(FUNCT3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        run_op(FUNCT3_MUL,    32'hFFFF_FFF6, 32'hFFFF_FFFD, 32'h0000_001E, "mul_negneg");

        // Start pulsed while busy and operands toggled after acceptance.
        issue(FUNCT3_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, "divu_busy");
        repeat (4) @(negedge clock);
        bus.start    = 1'b1;
        bus.funct3   = FUNCT3_MUL;
        bus.operand1 = 32'h1234_5678;
        bus.operand2 = 32'h9ABC_DEF0;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clock);
            bus.operand1 = $urandom;
            bus.operand2 = $urandom;
        end
        wait_idle("divu_busy");

        // Kill in the 11th ITER cycle.
        issue(FUNCT3_MUL, 32'd3, 32'd5, 1'b0, 32'd0, "killed");
        repeat (12) @(negedge clock);
        bus.kill = 1'b1;
        @(negedge clock);
        bus.kill = 1'b0;
        check("kill_busy", {31'b0, bus.busy}, 32'd0);
        check("kill_done", {31'b0, bus.done}, 32'd0);
        check("kill_result", bus.result, 32'd14);
        run_op(FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_after_kill");

        // Kill together with start in idle must not launch anything.
        bus.kill  = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        bus.kill  = 1'b0;
        bus.start = 1'b0;
        check("kill_start_idle_busy", {31'b0, bus.busy}, 32'd0);

        // Reset at cycle 20 of an operation.
        issue(FUNCT3_DIV, 32'd1000, 32'd3, 1'b0, 32'd0, "reset_mid");
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_busy", {31'b0, bus.busy}, 32'd0);
        check("midreset_done", {31'b0, bus.done}, 32'd0);
        check("midreset_result", bus.result, 32'd0);
        repeat (50) @(negedge clock);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
